// File: rtl/result_reader.sv
// result_reader: reads the five per-group sums and the grand total from the
// group-summing core's output memory, streams them over valid/ready, and
// checks that the group sums add up (modulo 2^DATA_WIDTH) to the stored total.
module result_reader #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 16,
  parameter int GROUP_STRIDE = 5,
  parameter int GROUP_COUNT  = 5,
  parameter int TOTAL_ADDR   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  done,
  output logic                  check_error
);

  // Index runs 0..GROUP_COUNT; the final index selects the grand total.
  localparam int IDX_W = $clog2(GROUP_COUNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [IDX_W-1:0]      w_next_idx;
  logic                  w_at_total;

  assign w_next_idx = r_idx + IDX_W'(1);
  assign w_at_total = (r_idx == LAST_IDX);

  // Group k's sum sits at the last word of its group; the final index reads the total.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] k);
    if (k == LAST_IDX) begin
      return ADDR_WIDTH'(TOTAL_ADDR);
    end
    return ADDR_WIDTH'(GROUP_STRIDE * int'(k) + GROUP_STRIDE - 1);
  endfunction

  // Readout FSM; every output is a register updated alongside the state.
  // NOTE: all state here is written with <= so every register samples the
  // pre-edge values; a blocking '=' would let later lines see updated values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch
    // inside the clocked block rather than part of the sensitivity list.
    if (reset) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_acc           <= '0;
      mem_address     <= '0;
      mem_read_enable <= 1'b0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      done            <= 1'b0;
      check_error     <= 1'b0;
    end else begin
      case (r_state)
        // A start from IDLE or DONE clears the run state and issues the first read.
        S_IDLE, S_DONE: begin
          if (start) begin
            r_acc           <= '0;
            r_idx           <= '0;
            check_error     <= 1'b0;
            done            <= 1'b0;
            mem_address     <= addr_of('0);
            mem_read_enable <= 1'b1;
            r_state         <= S_REQ;
          end
        end

        // The memory registers the word on this edge; drop the request.
        S_REQ: begin
          mem_read_enable <= 1'b0;
          r_state         <= S_WAIT;
        end

        // Read data is valid now: latch it for the sink, accumulate group sums.
        S_WAIT: begin
          out_data  <= mem_data_out;
          out_valid <= 1'b1;
          out_last  <= w_at_total;
          if (!w_at_total) begin
            r_acc <= r_acc + mem_data_out;
          end
          r_state <= S_SEND;
        end

        // Offer the word until accepted; data and last stay put meanwhile.
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (w_at_total) begin
              done        <= 1'b1;
              check_error <= (r_acc != out_data);
              r_state     <= S_DONE;
            end else begin
              r_idx           <= w_next_idx;
              mem_address     <= addr_of(w_next_idx);
              mem_read_enable <= 1'b1;
              r_state         <= S_REQ;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: table-driven readouts against a 32x16 synchronous memory
// model, with a scoreboard queue of expected stream words.
module tb_result_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  mem_address;
  logic        mem_read_enable;
  logic [15:0] mem_data_out;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        done;
  logic        check_error;

  result_reader dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mem_address     (mem_address),
    .mem_read_enable (mem_read_enable),
    .mem_data_out    (mem_data_out),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .done            (done),
    .check_error     (check_error)
  );

  always #5 clk = ~clk;

  // Shared 32x16 synchronous-read memory: data registered on the request edge.
  logic [15:0] mem [32];
  always @(posedge clk) begin
    if (mem_read_enable) mem_data_out <= mem[mem_address];
  end

  typedef struct {
    logic [5:0][15:0] words;   // words[0..4] group sums, words[5] stored total
    logic             exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  vec_t  vecs [4];
  exp_t  sb_q [$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    xfer_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: monitor/scoreboard at the falling edge, then advance past the
  // rising edge so the caller can drive the next inputs.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(prev_data));
      check("stall_last", 32'(out_last), 32'(prev_last));
      check("stall_no_read", 32'(mem_read_enable), 32'd0);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_word: got 0x%0h, want no transfer (cycle %0d)", out_data, cyc);
      end else begin
        e = sb_q.pop_front();
        check("word_data", 32'(out_data), 32'(e.data));
        check("word_last", 32'(out_last), 32'(e.last));
      end
      xfer_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_vec(input int vi);
    exp_t e;
    for (int i = 0; i < 32; i++) mem[i] = 16'(i);
    for (int k = 0; k < 5; k++) mem[5 * k + 4] = vecs[vi].words[k];
    mem[31] = vecs[vi].words[5];
    for (int k = 0; k < 6; k++) begin
      e.data = vecs[vi].words[k];
      e.last = (k == 5);
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    step();
    t0 = cyc;
    start = 1'b0;
    // First cycle after the start edge is REQ for address 4; done has dropped.
    check("start_req", 32'({done, mem_read_enable, mem_address}), 32'({1'b0, 1'b1, 5'd4}));
  endtask

  // Full readout; optional stall on one word and a start pulse while busy.
  task automatic run_readout(input int vi, input int stall_word, input int stall_cycles,
                             input int busy_word);
    int t0;
    int base;
    int left;
    bit pulsed;
    bit seen;
    load_vec(vi);
    base = xfer_cnt;
    pulse_start(t0);
    left   = stall_cycles;
    pulsed = 1'b0;
    seen   = 1'b0;
    for (int g = 0; g < 200; g++) begin
      if (out_valid && (xfer_cnt - base) == stall_word && left > 0) begin
        out_ready = 1'b0;
        left--;
      end else begin
        out_ready = 1'b1;
      end
      if (busy_word >= 0 && !pulsed && out_valid && (xfer_cnt - base) == busy_word) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got done=0, want done=1 within 200 cycles (vec %0d)", vi);
    end
    check("latency", 32'(cyc - t0), 32'(18 + stall_cycles));
    check("words_left", 32'(sb_q.size()), 32'd0);
    check("check_error", 32'(check_error), 32'(vecs[vi].exp_err));
    check("idle_valid", 32'({out_valid, out_last, mem_read_enable}), 32'd0);
    step();
    step();
    check("done_hold", 32'({done, check_error}), 32'({1'b1, vecs[vi].exp_err}));
  endtask

  initial begin
    int t0;
    int base;
    exp_t junk;

    vecs[0].words = {16'd230, 16'd86, 16'd66, 16'd46, 16'd26, 16'd6};       vecs[0].exp_err = 1'b0;
    vecs[1].words = {16'd229, 16'd86, 16'd66, 16'd46, 16'd26, 16'd6};       vecs[1].exp_err = 1'b1;
    vecs[2].words = {16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'hFFFF};          vecs[2].exp_err = 1'b0;
    vecs[3].words = {16'd15001, 16'd5000, 16'd4000, 16'd3000, 16'd2000, 16'd1000};
    vecs[3].exp_err = 1'b1;

    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 16'(i);
    step();
    step();
    reset = 1'b0;
    check("reset_state", 32'({mem_address, mem_read_enable, out_data, out_valid, out_last,
                              done, check_error}), 32'd0);
    step();
    check("idle_quiet", 32'({mem_read_enable, out_valid, done}), 32'd0);

    // Nominal, corrupt total, backpressure on 46, wrap, start while busy, extra vector.
    run_readout(0, -1, 0, -1);
    run_readout(1, -1, 0, -1);
    run_readout(0, 2, 4, -1);
    run_readout(2, -1, 0, -1);
    run_readout(0, -1, 0, 1);
    run_readout(3, -1, 0, -1);

    // Reset in the cycle after 46 transfers aborts the stream.
    load_vec(0);
    base = xfer_cnt;
    pulse_start(t0);
    for (int g = 0; g < 100 && (xfer_cnt - base) < 3; g++) step();
    check("pre_reset_count", 32'(xfer_cnt - base), 32'd3);
    reset = 1'b1;
    step();
    check("reset_mid", 32'({mem_address, mem_read_enable, out_data, out_valid, out_last,
                            done, check_error}), 32'd0);
    reset = 1'b0;
    while (sb_q.size() != 0) junk = sb_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_reset_valid", 32'({out_valid, mem_read_enable}), 32'd0);
    end
    run_readout(0, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
